uc_collector: RTL

//  Gathers unit-clause literals produced by the NUM_ENGINE propagation engines and presents them to
//  the unit-clause arbiter one engine at a time. One small circular FIFO per engine; the arbiter's
//  one-hot engmask selects which FIFO head drives eng2uca/eng2uca_empty. The arbiter pulses uca_pop

---
 rtl/uc_collector_if.sv | 25 ++
 rtl/uc_collector.sv | 134 +++++++++++++
 2 files changed

// File: rtl/uc_collector_if.sv
// rtl/uc_collector_if.sv - engine/arbiter-side handshake bundle for the unit-clause collector
// master: engines + arbiter side; slave: the collector.
interface uc_collector_if #(
    parameter int NUM_ENGINE = 4,
    parameter int LIT_W      = 6
);
    logic [NUM_ENGINE-1:0]             eng_valid;
    logic [NUM_ENGINE-1:0][LIT_W-1:0]  eng_lit;
    logic [NUM_ENGINE-1:0]             eng_ready;
    logic [NUM_ENGINE-1:0]             engmask;
    logic                              uca_pop;
    logic                              eng2uca_valid;
    logic                              eng2uca_empty;
    logic [LIT_W-1:0]                  eng2uca;

    modport master (
        output eng_valid, eng_lit, engmask, uca_pop,
        input  eng_ready, eng2uca_valid, eng2uca_empty, eng2uca
    );

    modport slave (
        input  eng_valid, eng_lit, engmask, uca_pop,
        output eng_ready, eng2uca_valid, eng2uca_empty, eng2uca
    );
endinterface

// File: rtl/uc_collector.sv
// rtl/uc_collector.sv - per-engine unit-literal FIFOs muxed to the arbiter by one-hot engmask
// Optional UC_COLLECT_DEDUP_EN: drop a push equal to the engine's last stored literal.
`ifndef NUM_ENGINE
`define NUM_ENGINE 4
`endif

module uc_collector #(
    parameter int NUM_ENGINE = `NUM_ENGINE,
    parameter int UC_LENGTH  = 64,
    parameter int DEPTH      = 4,
    localparam int LIT_W     = $clog2(UC_LENGTH),
    localparam int OCC_W     = $clog2(NUM_ENGINE * DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    uc_collector_if.slave    bus,
    output logic [OCC_W-1:0] occupancy,
    output logic [1:0]       err
);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);
    localparam logic [NUM_ENGINE-1:0] ONE = {{(NUM_ENGINE-1){1'b0}}, 1'b1};

    logic [LIT_W-1:0] r_mem    [NUM_ENGINE][DEPTH];
    logic [PW-1:0]    r_wr_ptr [NUM_ENGINE];
    logic [PW-1:0]    r_rd_ptr [NUM_ENGINE];
    logic [PW:0]      r_cnt    [NUM_ENGINE];
    logic [OCC_W-1:0] r_occ;
    logic [1:0]       r_err;

    logic                  w_onehot, w_multi, w_sel_empty, w_pop_err;
    logic [SW-1:0]         w_sel;
    logic [PW:0]           w_sel_cnt;
    logic [NUM_ENGINE-1:0] w_push, w_store, w_pop, w_dup;
    logic [PW:0]           w_cnt_nxt [NUM_ENGINE];
    logic [OCC_W-1:0]      w_occ_nxt;

`ifdef UC_COLLECT_DEDUP_EN
    logic [LIT_W-1:0]      r_last_lit [NUM_ENGINE];
    logic [NUM_ENGINE-1:0] r_last_vld;
`endif

    assign w_onehot = (bus.engmask != '0) && ((bus.engmask & (bus.engmask - ONE)) == '0);
    assign w_multi  = (bus.engmask != '0) && !w_onehot;

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_ENGINE; i++)
            if (bus.engmask[i]) w_sel = SW'(i);
    end

    // Head is shown only for a valid one-hot select; never a same-cycle write-through
    assign w_sel_cnt         = r_cnt[w_sel];
    assign w_sel_empty       = !w_onehot || (w_sel_cnt == '0);
    assign w_pop_err         = bus.uca_pop && w_onehot && (w_sel_cnt == '0);
    assign bus.eng2uca_empty = w_sel_empty;
    assign bus.eng2uca_valid = !w_sel_empty;
    assign bus.eng2uca       = w_sel_empty ? '0 : r_mem[w_sel][r_rd_ptr[w_sel]];
    assign occupancy         = r_occ;
    assign err               = r_err;

    always_comb begin
        bus.eng_ready = '0;
        w_push        = '0;
        w_store       = '0;
        w_pop         = '0;
        w_dup         = '0;
        w_occ_nxt     = '0;
        for (int i = 0; i < NUM_ENGINE; i++) begin
            w_cnt_nxt[i]  = '0;
            bus.eng_ready[i] = (r_cnt[i] != FULL) && !flush;
            w_push[i]     = bus.eng_valid[i] && bus.eng_ready[i];
`ifdef UC_COLLECT_DEDUP_EN
            w_dup[i]      = r_last_vld[i] && (bus.eng_lit[i] == r_last_lit[i]);
`endif
            w_store[i]    = w_push[i] && !w_dup[i];
            w_pop[i]      = bus.uca_pop && w_onehot && bus.engmask[i] && (r_cnt[i] != '0) && !flush;
            if (!flush)
                w_cnt_nxt[i] = r_cnt[i] + (PW + 1)'(w_store[i]) - (PW + 1)'(w_pop[i]);
            w_occ_nxt     = w_occ_nxt + OCC_W'(w_cnt_nxt[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
            r_err <= '0;
            for (int i = 0; i < NUM_ENGINE; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_cnt[i]    <= '0;
            end
        end else begin
            r_occ <= w_occ_nxt;
            r_err <= r_err | {w_multi, w_pop_err};
            for (int i = 0; i < NUM_ENGINE; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
                if (flush) begin
                    r_wr_ptr[i] <= '0;
                    r_rd_ptr[i] <= '0;
                end else begin
                    r_wr_ptr[i] <= r_wr_ptr[i] + PW'(w_store[i]);
                    r_rd_ptr[i] <= r_rd_ptr[i] + PW'(w_pop[i]);
                end
            end
        end
    end

    // Storage needs no reset: an entry is only visible while its count covers it
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENGINE; i++)
            if (w_store[i]) r_mem[i][r_wr_ptr[i]] <= bus.eng_lit[i];
    end

`ifdef UC_COLLECT_DEDUP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_vld <= '0;
            for (int i = 0; i < NUM_ENGINE; i++) r_last_lit[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_ENGINE; i++) begin
                if (flush) begin
                    r_last_vld[i] <= 1'b0;
                end else if (w_store[i]) begin
                    r_last_vld[i] <= 1'b1;
                    r_last_lit[i] <= bus.eng_lit[i];
                end
            end
        end
    end
`endif
endmodule
